// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   General-purpose register file with a HI/LO register pair. Serves the decode
//   stage's two combinational read ports and absorbs the write-back bus. Reads
//   see a same-cycle write (write-through bypass). Writes commit on the rising
//   clock edge. Register 0 is hard-wired to zero. HI and LO are always written
//   together.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst_n          synchronous active-low reset (clears GPRs, HI, LO)
//   re1/raddr1     read port 1 enable/address  -> rdata1 (combinational)
//   re2/raddr2     read port 2 enable/address  -> rdata2 (combinational)
//   we/waddr/wdata GPR write from write-back
//   whilo          HI/LO write enable, hi_i/lo_i write data
//   hi_o/lo_o      current HI/LO, bypassed from hi_i/lo_i while whilo=1
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [NREG];
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;

    // Read-port resolution: reset, disable and r0 force zero; a matching write
    // in flight is forwarded so decode never sees a stale value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_n_f,
        input logic              re_f,
        input logic [ADDR_W-1:0] raddr_f,
        input logic              we_f,
        input logic [ADDR_W-1:0] waddr_f,
        input logic [DATA_W-1:0] wdata_f,
        input logic [DATA_W-1:0] stored_f
    );
        logic [DATA_W-1:0] val;
        if (!rst_n_f) begin
            val = {DATA_W{1'b0}};
        end else if (!re_f) begin
            val = {DATA_W{1'b0}};
        end else if (raddr_f == {ADDR_W{1'b0}}) begin
            val = {DATA_W{1'b0}};
        end else if (we_f && (waddr_f == raddr_f)) begin
            val = wdata_f;
        end else begin
            val = stored_f;
        end
        return val;
    endfunction

    // State update: synchronous clear on reset, otherwise GPR and HI/LO writes
    // commit independently. Writes to r0 are dropped so r0 stays zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            hi_r <= {DATA_W{1'b0}};
            lo_r <= {DATA_W{1'b0}};
        end else begin
            if (we && (waddr != {ADDR_W{1'b0}})) begin
                regs_r[waddr] <= wdata;
            end
            if (whilo) begin
                hi_r <= hi_i;
                lo_r <= lo_i;
            end
        end
    end

    // Read port 1 data.
    always_comb begin
        rdata1 = read_port(rst_n, re1, raddr1, we, waddr, wdata, regs_r[raddr1]);
    end

    // Read port 2 data.
    always_comb begin
        rdata2 = read_port(rst_n, re2, raddr2, we, waddr, wdata, regs_r[raddr2]);
    end

    // HI/LO outputs with bypass from the pending move-to write.
    always_comb begin
        if (!rst_n) begin
            hi_o = {DATA_W{1'b0}};
            lo_o = {DATA_W{1'b0}};
        end else if (whilo) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end else begin
            hi_o = hi_r;
            lo_o = lo_r;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .we(we), .waddr(waddr), .wdata(wdata),
        .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
        int          step;
    } exp_t;

    exp_t q[$];

    // Reference model: architectural state as plain arrays/values.
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    int pass_count  = 0;
    int check_count = 0;
    int step_no     = 0;
    bit stim_done   = 1'b0;

    task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, step, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic rst, input logic re, input logic [4:0] a,
                                               input logic w, input logic [4:0] wa, input logic [31:0] wd);
        if (!rst || !re || a == 5'd0) return 32'd0;
        if (w && wa == a) return wd;
        return m_gpr[a];
    endfunction

    // Drive one cycle of stimulus, queue the expected outputs, then advance the model.
    task automatic apply(input logic rst, input logic r1e, input logic [4:0] a1,
                         input logic r2e, input logic [4:0] a2,
                         input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic hl, input logic [31:0] hv, input logic [31:0] lv);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; re1 = r1e; raddr1 = a1; re2 = r2e; raddr2 = a2;
        we = w; waddr = wa; wdata = wd; whilo = hl; hi_i = hv; lo_i = lv;
        e.r1   = model_read(rst, r1e, a1, w, wa, wd);
        e.r2   = model_read(rst, r2e, a2, w, wa, wd);
        e.hi   = !rst ? 32'd0 : (hl ? hv : m_hi);
        e.lo   = !rst ? 32'd0 : (hl ? lv : m_lo);
        e.step = step_no;
        step_no++;
        q.push_back(e);
        // The coming edge commits what was just presented.
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else begin
            if (w && wa != 5'd0) m_gpr[wa] = wd;
            if (hl) begin
                m_hi = hv;
                m_lo = lv;
            end
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("rdata1", e.step, rdata1, e.r1);
                check("rdata2", e.step, rdata2, e.r2);
                check("hi_o",   e.step, hi_o,   e.hi);
                check("lo_o",   e.step, lo_o,   e.lo);
            end
        end
    end

    initial begin
        logic [4:0] a1, a2, wa;
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        rst_n = 1'b0; re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
        we = 1'b0; waddr = 5'd0; wdata = 32'd0; whilo = 1'b0; hi_i = 32'd0; lo_i = 32'd0;

        // Initial reset with busy inputs: outputs must be zero.
        apply(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd1, 32'hCAFE_0001, 1'b1, 32'h5, 32'h6);
        apply(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);

        // Reset clears r5; write on the reset edge is lost.
        apply(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0);
        apply(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        apply(1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 32'h1111_2222, 1'b1, 32'h7, 32'h8);
        apply(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);

        // Write/read r7, then disabled port.
        apply(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 32'd0, 32'd0);
        apply(1'b1, 1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        apply(1'b1, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);

        // Bypass on r3 then hold.
        apply(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 32'd0, 32'd0);
        apply(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd3, 32'h0BAD_0BAD, 1'b0, 32'd0, 32'd0);

        // r0 ignores writes.
        apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0);
        apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);

        // HI/LO bypass and hold, with concurrent write to r9.
        apply(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd9, 32'h9999_0009, 1'b1, 32'h1, 32'h2);
        apply(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'hFF, 32'hEE);

        // Dual-port reads.
        apply(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h11, 1'b0, 32'd0, 32'd0);
        apply(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h22, 1'b0, 32'd0, 32'd0);
        apply(1'b1, 1'b1, 5'd4, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        apply(1'b1, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);

        // Randomized traffic; small address window half the time for collisions.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                a1 = 5'($urandom_range(3, 0)); a2 = 5'($urandom_range(3, 0)); wa = 5'($urandom_range(3, 0));
            end else begin
                a1 = 5'($urandom_range(31, 0)); a2 = 5'($urandom_range(31, 0)); wa = 5'($urandom_range(31, 0));
            end
            apply(($urandom_range(39, 0) != 0),
                  ($urandom_range(7, 0) != 0), a1,
                  ($urandom_range(7, 0) != 0), a2,
                  ($urandom_range(1, 0) == 1), wa, $urandom(),
                  ($urandom_range(3, 0) == 0), $urandom(), $urandom());
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        check_count++;
        if (q.size() == 0) begin
            pass_count++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
